tournament_predictor: RTL

Parametrised tournament (hybrid) branch predictor for the fetch stage: a gshare global predictor, a two-level local predictor and a meta chooser, plus a direct-mapped BTB. It predicts direction and target for the instruction in IF, registered one cycle after lookup, and trains from branch resolutions arriving from MEM. Tables are reset-initialised by an internal sweep FSM rather than a wide asynchronous clear.

---
 rtl/tournament_predictor_pkg.sv | 12 +
 rtl/bp_counter_table.sv | 24 ++
 rtl/tournament_predictor.sv | 118 +++++++++++
 3 files changed

// File: rtl/tournament_predictor_pkg.sv
// tournament_predictor_pkg: shared encodings and helpers for the tournament branch predictor.
package tournament_predictor_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [1:0] SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3;
  localparam logic [1:0] PHT_INIT = WNT, META_INIT = WT;
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    return up ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
  endfunction
  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2-bit saturating counter array with async read, RMW update and init-write ports.
module bp_counter_table
  import tournament_predictor_pkg::*;
#(
  parameter int IDX_BITS = 10
) (
  input  logic                CLK,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_up,
  output logic [1:0]          upd_ctr,
  input  logic                init_en,
  input  logic [IDX_BITS-1:0] init_idx,
  input  logic [1:0]          init_val
);
  logic [1:0] mem [2**IDX_BITS];
  assign rd_ctr  = mem[rd_idx];
  assign upd_ctr = mem[upd_idx];
  always_ff @(posedge CLK)
    if (init_en) mem[init_idx] <= init_val;
    else if (upd_en) mem[upd_idx] <= sat_step(upd_ctr, upd_up);
endmodule

// File: rtl/tournament_predictor.sv
// tournament_predictor: gshare + two-level local predictor with meta chooser and direct-mapped BTB.
// Tables are initialised by a sweep FSM after reset; training is non-speculative at resolution.
module tournament_predictor
  import tournament_predictor_pkg::*;
#(
  parameter int GHR_BITS      = 10,
  parameter int LHT_IDX_BITS  = 8,
  parameter int LHIST_BITS    = 8,
  parameter int META_IDX_BITS = 10,
  parameter int BTB_IDX_BITS  = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        Lookup_valid,
  input  logic        Lookup_is_branch,
  input  logic [31:0] Lookup_pc,
  input  logic        Update_valid,
  input  logic [31:0] Update_pc,
  input  logic        Update_taken,
  input  logic [31:0] Update_target,
  output logic        Ready,
  output logic        Pred_valid,
  output logic        Pred_taken,
  output logic [31:0] Pred_target
);
  localparam int MAXIDX = imax(imax(imax(GHR_BITS, LHT_IDX_BITS), imax(LHIST_BITS, META_IDX_BITS)), BTB_IDX_BITS);
  localparam int TAG_BITS = 30 - BTB_IDX_BITS;

  state_t state, state_nx;
  logic [MAXIDX-1:0] sweep;
  logic init_en, ready, upd, act, hit, lk_dir;
  logic [GHR_BITS-1:0] ghr, lk_g, up_g;
  logic [LHT_IDX_BITS-1:0] lk_h, up_h;
  logic [LHIST_BITS-1:0] lk_l, up_l;
  logic [BTB_IDX_BITS-1:0] lk_b, up_b;
  logic [1:0] g_rd, l_rd, m_rd, g_up, l_up, m_up;
  logic [LHIST_BITS-1:0] lht [2**LHT_IDX_BITS];
  logic btb_v [2**BTB_IDX_BITS];
  logic [TAG_BITS-1:0] btb_tag [2**BTB_IDX_BITS];
  logic [31:0] btb_tgt [2**BTB_IDX_BITS];
  logic unused;

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) state <= INIT;
    else state <= state_nx;

  always_comb state_nx = (state == INIT && &sweep) ? RUN : state;

  always_comb begin
    init_en = state == INIT;
    ready   = state == RUN;
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) sweep <= '0;
    else sweep <= init_en ? sweep + MAXIDX'(1) : '0;

  assign Ready = ready;
  assign upd   = Update_valid & ready;
  assign act   = Lookup_valid & ready & ~FLUSH;
  assign lk_g  = Lookup_pc[GHR_BITS+1:2] ^ ghr;
  assign up_g  = Update_pc[GHR_BITS+1:2] ^ ghr;
  assign lk_h  = Lookup_pc[LHT_IDX_BITS+1:2];
  assign up_h  = Update_pc[LHT_IDX_BITS+1:2];
  assign lk_l  = lht[lk_h];
  assign up_l  = lht[up_h];
  assign lk_b  = Lookup_pc[BTB_IDX_BITS+1:2];
  assign up_b  = Update_pc[BTB_IDX_BITS+1:2];
  assign hit   = btb_v[lk_b] && btb_tag[lk_b] == Lookup_pc[31:BTB_IDX_BITS+2];
  assign lk_dir = m_rd[1] ? g_rd[1] : l_rd[1];
  assign unused = ^{Lookup_pc[1:0], Update_pc[1:0], m_up};

  bp_counter_table #(.IDX_BITS(GHR_BITS)) u_gpht (
    .CLK(CLK), .rd_idx(lk_g), .rd_ctr(g_rd), .upd_en(upd), .upd_idx(up_g),
    .upd_up(Update_taken), .upd_ctr(g_up), .init_en(init_en),
    .init_idx(sweep[GHR_BITS-1:0]), .init_val(PHT_INIT));

  bp_counter_table #(.IDX_BITS(LHIST_BITS)) u_lpht (
    .CLK(CLK), .rd_idx(lk_l), .rd_ctr(l_rd), .upd_en(upd), .upd_idx(up_l),
    .upd_up(Update_taken), .upd_ctr(l_up), .init_en(init_en),
    .init_idx(sweep[LHIST_BITS-1:0]), .init_val(PHT_INIT));

  // Meta only learns when the two components disagree; it moves toward global when global was right.
  bp_counter_table #(.IDX_BITS(META_IDX_BITS)) u_meta (
    .CLK(CLK), .rd_idx(Lookup_pc[META_IDX_BITS+1:2]), .rd_ctr(m_rd),
    .upd_en(upd & (g_up[1] != l_up[1])), .upd_idx(Update_pc[META_IDX_BITS+1:2]),
    .upd_up(g_up[1] == Update_taken), .upd_ctr(m_up), .init_en(init_en),
    .init_idx(sweep[META_IDX_BITS-1:0]), .init_val(META_INIT));

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) ghr <= '0;
    else if (upd) ghr <= {ghr[GHR_BITS-2:0], Update_taken};

  always_ff @(posedge CLK)
    if (init_en) begin
      lht[sweep[LHT_IDX_BITS-1:0]] <= '0;
      btb_v[sweep[BTB_IDX_BITS-1:0]] <= 1'b0;
    end else if (upd) begin
      lht[up_h] <= {up_l[LHIST_BITS-2:0], Update_taken};
      if (Update_taken) begin
        btb_v[up_b]   <= 1'b1;
        btb_tag[up_b] <= Update_pc[31:BTB_IDX_BITS+2];
        btb_tgt[up_b] <= Update_target;
      end
    end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      Pred_valid  <= 1'b0;
      Pred_taken  <= 1'b0;
      Pred_target <= '0;
    end else begin
      Pred_valid  <= act;
      Pred_taken  <= act & Lookup_is_branch & lk_dir & hit;
      Pred_target <= (act & hit) ? btb_tgt[lk_b] : '0;
    end
endmodule
